// File: rtl/branch_predict_fetch_if.sv
// Fetch/resolve bundle between the core and the next-PC generator.
//   master : core side   - drives stall and the decode-stage resolution inputs
//   slave  : predictor   - drives the fetch PC, the prediction, redirect and
//                          the mispredict counter
interface branch_predict_fetch_if;
  // fetch side
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  // decode-stage resolution
  logic        res_valid;
  logic [31:0] res_instr;
  logic [31:0] res_pc;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        eq;
  logic [31:0] vs;
  logic        redirect;
  logic [31:0] mispredicts;

  modport master (
    output stall, res_valid, res_instr, res_pc, res_pred_taken, res_pred_target, eq, vs,
    input  pc, pred_taken, pred_target, redirect, mispredicts
  );

  modport slave (
    input  stall, res_valid, res_instr, res_pc, res_pred_taken, res_pred_target, eq, vs,
    output pc, pred_taken, pred_target, redirect, mispredicts
  );
endinterface

// File: rtl/branch_predict_fetch.sv
// Next-PC generator for the pipelined MIPS core.
// Owns the fetch PC, predicts the next fetch address from a direct-mapped BTB
// with 2-bit saturating counters, resolves control transfers in decode and
// redirects fetch on a mispredict.
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : branch_predict_fetch_if.slave (fetch PC / prediction out,
//            decode resolution in, redirect and mispredict count out)

// One BTB entry: a plain enabled register with its own reset value.
module bpf_btb_entry #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  q <= RST;
    else if (we)  q <= d;
  end
endmodule

module branch_predict_fetch #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic                  clk,
  input  logic                  resetn,
  branch_predict_fetch_if.slave bus
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic            vld;
    logic [TAGW-1:0] tag;
    logic [31:0]     tgt;
    logic [1:0]      ctr;
  } btb_ent_t;

  localparam int       EW      = $bits(btb_ent_t);
  localparam btb_ent_t ENT_RST = '{vld: 1'b0, tag: '0, tgt: '0, ctr: CTR_INIT};

  logic [ENTRIES-1:0][EW-1:0] ent_q;
  logic [ENTRIES-1:0]         ent_we;
  btb_ent_t                   upd_d;
  logic                       upd_we;
  logic [IDX-1:0]             u_idx;

  // BTB storage: one register per entry, single shared write port
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    assign ent_we[i] = upd_we & (u_idx == IDX'(i));
    bpf_btb_entry #(.W(EW), .RST(EW'(ENT_RST))) u_ent (
      .clk    (clk),
      .resetn (resetn),
      .we     (ent_we[i]),
      .d      (upd_d),
      .q      (ent_q[i])
    );
  end

  // ---------------------------------------------------------------- lookup
  logic [31:0] pc_q, pc_d;
  logic [31:0] mis_q;
  btb_ent_t    f_ent;
  logic        f_hit, f_taken;
  logic [31:0] f_target;

  // Reads the registered contents only: a write this edge is seen next cycle.
  assign f_ent    = btb_ent_t'(ent_q[pc_q[IDX+1:2]]);
  assign f_hit    = f_ent.vld & (f_ent.tag == pc_q[31:IDX+2]);
  assign f_taken  = f_hit & (f_ent.ctr >= 2'b10);
  assign f_target = f_taken ? f_ent.tgt : 32'h0;

  // ---------------------------------------------------------------- resolve
  logic [5:0]  op, fn;
  logic        is_jr, is_j, is_br, br_taken;
  logic [31:0] npc, br_tgt, j_tgt, act_npc, pred_npc;
  logic        redirect;

  always_comb begin
    op       = bus.res_instr[31:26];
    fn       = bus.res_instr[5:0];
    npc      = bus.res_pc + 32'd4;
    br_tgt   = npc + {{14{bus.res_instr[15]}}, bus.res_instr[15:0], 2'b00};
    j_tgt    = {npc[31:28], bus.res_instr[25:0], 2'b00};
    is_jr    = (op == OP_RTYPE) & (fn == FN_JR);
    is_j     = (op == OP_J) | (op == OP_JAL);
    is_br    = (op == OP_BEQ) | (op == OP_BNE);
    br_taken = (op == OP_BEQ) ? bus.eq : ((op == OP_BNE) & ~bus.eq);
    act_npc  = npc;
    if (is_jr)         act_npc = bus.vs;
    else if (is_j)     act_npc = j_tgt;
    else if (br_taken) act_npc = br_tgt;
    pred_npc = bus.res_pred_taken ? bus.res_pred_target : npc;
  end

  assign redirect = resetn & bus.res_valid & (pred_npc != act_npc);

  // ---------------------------------------------------------------- update
  btb_ent_t u_ent;
  logic     u_hit;
  logic [TAGW-1:0] u_tag;

  assign u_idx = bus.res_pc[IDX+1:2];
  assign u_tag = bus.res_pc[31:IDX+2];
  assign u_ent = btb_ent_t'(ent_q[u_idx]);
  assign u_hit = u_ent.vld & (u_ent.tag == u_tag);

  always_comb begin
    upd_d  = u_ent;
    upd_we = 1'b0;
    if (bus.res_valid) begin
      if (is_jr | is_j) begin
        upd_we = 1'b1;
        upd_d  = '{vld: 1'b1, tag: u_tag, tgt: act_npc, ctr: 2'b11};
      end else if (is_br) begin
        if (u_hit) begin
          upd_we    = 1'b1;
          upd_d.tgt = br_tgt;
          if (br_taken) upd_d.ctr = (u_ent.ctr == 2'b11) ? 2'b11 : u_ent.ctr + 2'd1;
          else          upd_d.ctr = (u_ent.ctr == 2'b00) ? 2'b00 : u_ent.ctr - 2'd1;
        end else if (br_taken) begin
          upd_we = 1'b1;
          upd_d  = '{vld: 1'b1, tag: u_tag, tgt: br_tgt, ctr: 2'b10};
        end
      end else if (u_hit) begin
        // a non-control instruction owns this PC now: drop the stale entry
        upd_we    = 1'b1;
        upd_d.vld = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- fetch PC
  // Redirect beats stall: the wrong-path instruction must not be held.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect)     pc_d = act_npc;
    else if (bus.stall) pc_d = pc_q;
    else if (f_taken) pc_d = f_target;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q  <= RESET_PC;
      mis_q <= 32'h0;
    end else begin
      pc_q  <= pc_d;
      if (redirect) mis_q <= mis_q + 32'd1;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = f_taken;
  assign bus.pred_target = f_target;
  assign bus.redirect    = redirect;
  assign bus.mispredicts = mis_q;
endmodule

// File: tb/tb_branch_predict_fetch.sv
// Bench for branch_predict_fetch: directed scenarios plus a randomized run,
// all checked against a behavioural model of the BTB and fetch PC.
module tb_branch_predict_fetch;
  localparam int ENT = 16;
  localparam int IDX = 4;
  localparam logic [31:0] NOP = 32'h0000_0020;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  branch_predict_fetch_if bus();

  branch_predict_fetch #(.ENTRIES(ENT), .RESET_PC(32'h3000), .CTR_INIT(2'b01)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
    else n_pass++;
  endtask

  // ---------------- reference model
  bit [31:0] m_pc, m_mis;
  bit        m_v[ENT];
  bit [31:0] m_tag[ENT], m_tgt[ENT];
  int        m_ctr[ENT];
  bit        e_pt, e_redir;
  bit [31:0] e_ptgt;
  logic        o_pt, o_redir;
  logic [31:0] o_ptgt;

  task automatic m_reset();
    m_pc = 32'h3000; m_mis = 0;
    for (int i = 0; i < ENT; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance model.
  task automatic step(input bit st, input bit rv, input bit [31:0] ins, input bit [31:0] rpc,
                      input bit rpt, input bit [31:0] rptgt, input bit e, input bit [31:0] v);
    int fi, ui, kind;
    bit hit, uh, taken;
    bit [31:0] npc, btgt, act, pred;
    bus.stall = st; bus.res_valid = rv; bus.res_instr = ins; bus.res_pc = rpc;
    bus.res_pred_taken = rpt; bus.res_pred_target = rptgt; bus.eq = e; bus.vs = v;
    @(negedge clk);
    fi     = int'((m_pc >> 2) % ENT);
    hit    = m_v[fi] && m_tag[fi] == (m_pc >> (IDX + 2));
    e_pt   = hit && m_ctr[fi] >= 2;
    e_ptgt = e_pt ? m_tgt[fi] : 0;
    npc    = rpc + 4;
    btgt   = npc + 32'($signed(ins[15:0]) * 4);
    kind   = 0; taken = 0; act = npc;
    if (ins[31:26] == 0 && ins[5:0] == 8) begin kind = 1; act = v; end
    else if (ins[31:26] == 2 || ins[31:26] == 3) begin
      kind = 1; act = (npc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    end else if (ins[31:26] == 4 || ins[31:26] == 5) begin
      kind = 2; taken = (ins[31:26] == 4) ? e : !e;
      if (taken) act = btgt;
    end
    pred    = rpt ? rptgt : npc;
    e_redir = rv && pred != act;
    o_pt = bus.pred_taken; o_ptgt = bus.pred_target; o_redir = bus.redirect;
    chk("pc", bus.pc, m_pc);
    chk("pred_taken", 32'(bus.pred_taken), 32'(e_pt));
    chk("pred_target", bus.pred_target, e_ptgt);
    chk("redirect", 32'(bus.redirect), 32'(e_redir));
    chk("mispredicts", bus.mispredicts, m_mis);
    if (rv) begin
      ui = int'((rpc >> 2) % ENT);
      uh = m_v[ui] && m_tag[ui] == (rpc >> (IDX + 2));
      if (kind == 1) begin
        m_v[ui] = 1; m_tag[ui] = rpc >> (IDX + 2); m_tgt[ui] = act; m_ctr[ui] = 3;
      end else if (kind == 2) begin
        if (uh) begin
          m_tgt[ui] = btgt;
          m_ctr[ui] = taken ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3) : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
        end else if (taken) begin
          m_v[ui] = 1; m_tag[ui] = rpc >> (IDX + 2); m_tgt[ui] = btgt; m_ctr[ui] = 2;
        end
      end else if (uh) m_v[ui] = 0;
    end
    if (e_redir)     m_pc = act;
    else if (st)     m_pc = m_pc;
    else if (e_pt)   m_pc = e_ptgt;
    else             m_pc = m_pc + 4;
    if (e_redir) m_mis = m_mis + 1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, NOP, 0, 0, 0, 0, 0);
  endtask

  // Force fetch to addr via a deliberately wrong prediction on the preceding NOP.
  task automatic goto(input bit [31:0] addr);
    step(0, 1, NOP, addr - 4, 1, addr + 32'h100, 0, 0);
  endtask

  bit [31:0] imem[64];
  bit        if_v, if_pt, st;
  bit [31:0] if_pc, if_ptgt, pre_pc, mis0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.stall = 0; bus.res_valid = 0; bus.res_instr = 0; bus.res_pc = 0;
    bus.res_pred_taken = 0; bus.res_pred_target = 0; bus.eq = 0; bus.vs = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 32'h3000);
    chk("rst_pt", 32'(bus.pred_taken), 0);
    chk("rst_mis", bus.mispredicts, 0);
    resetn = 1;
    idle(); idle();
    chk("pc_3008", bus.pc, 32'h3008);

    // taken BEQ, first encounter, then predicted on refetch
    step(0, 1, 32'h1000_0004, 32'h3010, 0, 0, 1, 0);
    chk("beq_redir", 32'(o_redir), 1);
    chk("beq_pc", bus.pc, 32'h3024);
    goto(32'h3010);
    idle();
    chk("beq_pt", 32'(o_pt), 1);
    chk("beq_ptgt", o_ptgt, 32'h3024);
    step(0, 1, 32'h1000_0004, 32'h3010, 1, 32'h3024, 1, 0);
    chk("beq_ok", 32'(o_redir), 0);

    // counter at 11: one not-taken flips the outcome but not the prediction
    step(0, 1, 32'h1000_0004, 32'h3010, 1, 32'h3024, 0, 0);
    chk("hyst_redir", 32'(o_redir), 1);
    goto(32'h3010);
    idle();
    chk("hyst_pt", 32'(o_pt), 1);

    // JR target change
    step(0, 1, 32'h0000_0008, 32'h3040, 0, 0, 0, 32'h3100);
    step(0, 1, 32'h0000_0008, 32'h3040, 1, 32'h3100, 0, 32'h3200);
    chk("jr_redir", 32'(o_redir), 1);
    chk("jr_pc", bus.pc, 32'h3200);
    goto(32'h3040);
    idle();
    chk("jr_ptgt", o_ptgt, 32'h3200);

    // stall together with a mispredicting BNE, then stall alone
    mis0 = m_mis;
    step(1, 1, 32'h1400_0008, 32'h3080, 0, 0, 0, 0);
    chk("stl_pc", bus.pc, 32'h30A4);
    chk("stl_mis", bus.mispredicts, mis0 + 1);
    step(1, 0, NOP, 0, 0, 0, 0, 0);
    chk("stl_hold", bus.pc, 32'h30A4);

    // aliasing: a non-control miss at the same index does not evict
    step(0, 1, 32'h1000_0004, 32'h3000, 0, 0, 1, 0);
    step(0, 1, NOP, 32'h3040, 0, 0, 0, 0);
    goto(32'h3000);
    idle();
    chk("alias_pt", 32'(o_pt), 1);
    chk("alias_ptgt", o_ptgt, 32'h3014);

    // pc + 4 wraps at 32 bits
    goto(32'hFFFF_FFFC);
    idle();
    chk("pc_wrap", bus.pc, 32'h0);

    // randomized run over a small program region
    for (int k = 0; k < 64; k++) begin
      int r;
      bit [15:0] im;
      r  = int'($urandom_range(0, 99));
      im = 16'($urandom_range(0, 16)) - 16'd8;
      if (r < 40)      imem[k] = NOP | ($urandom & 32'h03FF_F800);
      else if (r < 65) imem[k] = {6'h04, 10'($urandom), im};
      else if (r < 80) imem[k] = {6'h05, 10'($urandom), im};
      else if (r < 90) imem[k] = {(r < 85) ? 6'h02 : 6'h03, 26'((32'h3000 + 4 * $urandom_range(0, 63)) >> 2)};
      else             imem[k] = 32'h0000_0008 | ({27'($urandom), 5'h0} & 32'h03E0_0000);
    end
    goto(32'h3000);
    if_v = 0; if_pc = 0; if_pt = 0; if_ptgt = 0;
    for (int c = 0; c < 2000; c++) begin
      bit rv;
      st     = ($urandom_range(0, 4) == 0);
      rv     = if_v && ($urandom_range(0, 9) != 0);
      pre_pc = m_pc;
      step(st, rv, imem[(if_pc >> 2) % 64], if_pc, if_pt, if_ptgt,
           1'($urandom_range(0, 1)), 32'h3000 + 4 * $urandom_range(0, 63));
      if (e_redir) if_v = 0;
      else if (!st) begin
        if_v = 1; if_pc = pre_pc; if_pt = e_pt; if_ptgt = e_ptgt;
      end
    end

    // reset mid-operation discards BTB history
    resetn = 0;
    #2;
    chk("mrst_pc", bus.pc, 32'h3000);
    chk("mrst_mis", bus.mispredicts, 0);
    m_reset();
    @(posedge clk); #1;
    resetn = 1;
    step(0, 1, 32'h1000_0004, 32'h3000, 0, 0, 1, 0);
    step(0, 1, 32'h1000_0004, 32'h3000, 1, 32'h3014, 1, 0);
    goto(32'h3000);
    idle();
    chk("mrst_retrain", 32'(o_pt), 1);
    resetn = 0;
    #2;
    m_reset();
    @(posedge clk); #1;
    resetn = 1;
    idle();
    chk("mrst_cold", 32'(o_pt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
